// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Deframes the serial stream coming out of the 4-stage shift register into
//   parallel words. Frame: start '1', DATA_W data bits MSB first, optional
//   parity bit, stop '0'. The idle line is '0'.
//   Received words sit in a one-entry valid/ready buffer together with their
//   parity status. Framing errors give a one-cycle pulse, and an overrun is
//   recorded in a sticky flag.
// Ports
//   CLK        : clock, all state changes on posedge
//   Reset      : synchronous active-high reset, wins over every other input
//   Serial_in  : serial bit stream
//   rx_ready   : consumer accepts rx_data while rx_valid=1
//   clr_err    : clears the sticky overrun flag
//   rx_data    : received word, stable while rx_valid=1
//   rx_valid   : buffer holds a word that has not been accepted yet
//   parity_err : parity mismatch for the buffered word
//   frame_err  : one-cycle pulse, stop bit sampled as '1'
//   overrun    : sticky, a good frame was dropped because the buffer was full
//   busy       : receiver is inside a frame
module serial_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Serial_in,
  input  logic              rx_ready,
  input  logic              clr_err,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic             HAS_PAR  = (PARITY_EN != 0);
  localparam logic             ODD_SEL  = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [DATA_W-1:0] shift_r;
  logic [DATA_W:0]   shift_ext_s;
  logic              perr_r;
  logic              load_s;
  logic              drop_s;
  logic              ferr_s;

  // XOR of the data bits and the received parity bit; 0 means an even total.
  function automatic logic parity_of(input logic [DATA_W-1:0] data, input logic pbit);
    return (^data) ^ pbit;
  endfunction

  // The top bit of this extension falls off the shift register each data cycle.
  assign shift_ext_s = {shift_r, Serial_in};

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. A '1' seen during STOP is a framing error, not a start bit.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (Serial_in) begin
          state_nxt_s = S_DATA;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_DATA: begin
        if (bit_cnt_r == LAST_BIT) begin
          state_nxt_s = HAS_PAR ? S_PARITY : S_STOP;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_PARITY: state_nxt_s = S_STOP;
      S_STOP:   state_nxt_s = S_IDLE;
      default:  state_nxt_s = S_IDLE;
    endcase
  end

  // Stop-bit decisions: load into the buffer, drop as overrun, or flag a framing error.
  always_comb begin
    load_s = 1'b0;
    drop_s = 1'b0;
    ferr_s = 1'b0;
    if (state_r == S_STOP) begin
      if (!Serial_in) begin
        if (!rx_valid || rx_ready) begin
          load_s = 1'b1;
        end else begin
          drop_s = 1'b1;
        end
      end else begin
        ferr_s = 1'b1;
      end
    end else begin
      load_s = 1'b0;
      drop_s = 1'b0;
      ferr_s = 1'b0;
    end
  end

  // Bit counter, data shift register and parity capture.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      bit_cnt_r <= {CNT_W{1'b0}};
      shift_r   <= {DATA_W{1'b0}};
      perr_r    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          bit_cnt_r <= {CNT_W{1'b0}};
          perr_r    <= 1'b0;
        end
        S_DATA: begin
          shift_r   <= shift_ext_s[DATA_W-1:0];
          bit_cnt_r <= bit_cnt_r + CNT_W'(1);
        end
        S_PARITY: perr_r <= (parity_of(shift_r, Serial_in) != ODD_SEL);
        S_STOP:   perr_r <= perr_r;
        default:  bit_cnt_r <= {CNT_W{1'b0}};
      endcase
    end
  end

  // Output buffer and status flags. When overrun is set and cleared in the same cycle, the set wins.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      rx_data    <= {DATA_W{1'b0}};
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (load_s) begin
        rx_data    <= shift_r;
        parity_err <= perr_r;
        rx_valid   <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
      end
      if (drop_s) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
      frame_err <= ferr_s;
      busy      <= (state_nxt_s != S_IDLE);
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx. Stimulus tasks build whole frames
// from words and push the expected word into a queue. A negedge monitor
// compares DUT outputs against that queue and against the expected flags.
module tb_serial_frame_rx;
  localparam int W = 8;

  logic CLK = 1'b0;
  logic Reset, Serial_in, rx_ready, clr_err;
  logic [W-1:0] rx_data;
  logic rx_valid, parity_err, frame_err, overrun, busy;

  logic s2;
  logic [W-1:0] d2;
  logic v2, p2, f2, o2, b2;

  always #5 CLK = ~CLK;

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .CLK(CLK), .Reset(Reset), .Serial_in(Serial_in), .rx_ready(rx_ready),
    .clr_err(clr_err), .rx_data(rx_data), .rx_valid(rx_valid),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_np (
    .CLK(CLK), .Reset(Reset), .Serial_in(s2), .rx_ready(1'b0),
    .clr_err(1'b0), .rx_data(d2), .rx_valid(v2),
    .parity_err(p2), .frame_err(f2), .overrun(o2), .busy(b2)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       p;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  int   rdy_mode = 0;     // 0: never ready, 1: always ready, 2: random
  bit   clr_rand = 1'b0;
  bit   m_valid, m_overrun, m_ferr, m_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit rc();
    return clr_rand && ($urandom_range(0, 15) == 0);
  endfunction

  // One clock of stimulus. The expected state after the coming posedge follows the buffer rules.
  task automatic tick(input logic s, input bit is_stop, input logic [7:0] w,
                      input logic pe, input bit busy_after, input bit clr);
    logic rdy;
    bit   nv, no, load, drop;
    case (rdy_mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      default: rdy = ($urandom_range(0, 1) == 1);
    endcase
    Reset = 1'b0; Serial_in = s; rx_ready = rdy; clr_err = clr;
    load = is_stop && !s && (!m_valid || rdy);
    drop = is_stop && !s && m_valid && !rdy;
    nv = load ? 1'b1 : ((m_valid && rdy) ? 1'b0 : m_valid);
    no = drop ? 1'b1 : (clr ? 1'b0 : m_overrun);
    @(posedge CLK);
    if (load) q.push_back('{d: w, p: pe});
    m_valid = nv; m_overrun = no; m_ferr = is_stop && s; m_busy = busy_after;
    #1;
  endtask

  task automatic idle(input int n, input bit clr);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, clr | rc());
  endtask

  task automatic send_frame(input logic [7:0] w, input logic pbit, input logic stopb);
    logic pe;
    pe = ((($countones(w) + int'(pbit)) % 2) != 0);
    tick(1'b1, 1'b0, w, pe, 1'b1, rc());
    for (int i = 7; i >= 0; i--) tick(w[i], 1'b0, w, pe, 1'b1, rc());
    tick(pbit, 1'b0, w, pe, 1'b1, rc());
    tick(stopb, 1'b1, w, pe, 1'b0, rc());
  endtask

  task automatic do_reset();
    Reset = 1'b1; Serial_in = 1'b0; rx_ready = 1'b0; clr_err = 1'b0;
    @(posedge CLK);
    q.delete();
    m_valid = 1'b0; m_overrun = 1'b0; m_ferr = 1'b0; m_busy = 1'b0;
    #1;
  endtask

  task automatic drain();
    int keep;
    keep = rdy_mode;
    rdy_mode = 1;
    idle(2, 1'b0);
    rdy_mode = keep;
  endtask

  // Monitor: every cycle check the flags, and check the word whenever rx_valid is high.
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("rx_valid", rx_valid, m_valid);
      chk("busy", busy, m_busy);
      chk("frame_err", frame_err, m_ferr);
      chk("overrun", overrun, m_overrun);
      if (rx_valid === 1'b1) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_word: got %0h expected none", rx_data);
        end else begin
          chk("rx_data", rx_data, q[0].d);
          chk("parity_err", parity_err, q[0].p);
          if (rx_ready === 1'b1) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0] w;
    logic [9:0] np_bits;
    s2 = 1'b0;
    Reset = 1'b1; Serial_in = 1'b0; rx_ready = 1'b0; clr_err = 1'b0;
    do_reset();
    do_reset();
    mon_en = 1'b1;
    chk("reset_data", rx_data, 8'h00);
    chk("reset_perr", parity_err, 1'b0);

    // Good frame with the consumer stalled, then a parity error.
    rdy_mode = 0;
    send_frame(8'hA5, 1'b0, 1'b0);
    idle(2, 1'b0);
    drain();
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(1, 1'b0);
    drain();

    // Framing error, immediately followed by a good frame.
    send_frame(8'hA5, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(1, 1'b0);
    drain();

    // Overrun: the second frame is dropped; then clear the sticky flag.
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("ovr_set", overrun, 1'b1);
    chk("ovr_data", rx_data, 8'h11);
    idle(1, 1'b1);
    chk("ovr_clr", overrun, 1'b0);
    drain();

    // Back-to-back frames with the consumer always ready.
    rdy_mode = 1;
    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h80, 1'b1, 1'b0);
    idle(3, 1'b0);

    // Reset after four data bits, then a full frame.
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    do_reset();
    chk("midrst_data", rx_data, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_valid", rx_valid, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Random frames, gaps, readiness, error injection and overrun clears.
    rdy_mode = 2;
    clr_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      w = 8'($urandom);
      send_frame(w, (^w) ^ ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      idle($urandom_range(0, 2), 1'b0);
    end
    clr_rand = 1'b0;
    rdy_mode = 1;
    idle(4, 1'b0);
    chk("scoreboard_drained", q.size(), 0);

    // Build without a parity bit: a 10-cycle frame carrying 8'h5A.
    np_bits = {1'b1, 8'h5A, 1'b0};
    for (int i = 9; i >= 0; i--) begin
      s2 = np_bits[i];
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    s2 = 1'b0;
    @(negedge CLK);
    chk("np_valid", v2, 1'b1);
    chk("np_data", d2, 8'h5A);
    chk("np_perr", p2, 1'b0);
    chk("np_ferr", f2, 1'b0);
    chk("np_busy", b2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
